// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared ALU
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  input  logic        resp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   prio;
  logic   grant_any;
  logic   grant_id;
  logic   accept;

  // Choose the requester to grant: a lone valid wins, a tie goes to the priority pointer.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and handshake outputs; readies only in IDLE and never while reset is applied.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && grant_any) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and round-robin pointer; the pointer moves only when a request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= RR_INIT;
    end else begin
      state <= state_next;
      if (accept) begin
        prio <= ~grant_id;
      end
    end
  end

  // Payload capture on accept and ALU result capture in EXEC; everything else holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op      <= 4'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_shamt   <= 5'd0;
      resp_id     <= 1'b0;
      resp_result <= 32'd0;
      resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_op    <= grant_id ? req1_op    : req0_op;
        alu_a     <= grant_id ? req1_a     : req0_a;
        alu_b     <= grant_id ? req1_b     : req0_b;
        alu_shamt <= grant_id ? req1_shamt : req0_shamt;
        resp_id   <= grant_id;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 reqN_op  input  4  ALU operation code (AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SHIFT 1110).
REQ-007 reqN_a / reqN_b  input  32  operands A and B.
REQ-008 reqN_shamt  input  5  shift amount.
REQ-009 alu_op  output  4, alu_a / alu_b  output  32, alu_shamt  output  5  registered drive to the shared ALU.
REQ-010 alu_result  input  32, alu_zero  input  1  combinational ALU return.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_id  output  1  requester index that owns the response.
REQ-013 resp_result  output  32, resp_zero  output  1  captured ALU outputs.
REQ-014 resp_ready  input  1  consumer accepts the response.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; transfer on any handshake = valid & ready high in the same cycle.
REQ-016 IDLE: reqN_ready high only for the single granted requester; at most one ready high per cycle; no ready in EXEC or RESP.
REQ-017 Grant in IDLE: only one valid -> that requester; both valid -> requester holding priority pointer; none valid -> no grant, stay IDLE.
REQ-018 On accept: latch op/a/b/shamt into ALU drive registers, latch requester index, update priority pointer to the other requester, go EXEC.
REQ-019 EXEC (one cycle): capture alu_result and alu_zero into resp registers, go RESP.
REQ-020 RESP: resp_valid high, resp_id/result/zero stable until resp_ready; on resp_ready go IDLE.
REQ-021 Latency: accept in cycle N -> resp_valid high from cycle N+2; minimum initiation interval 3 cycles with resp_ready tied high.
REQ-022 Priority pointer changes only on accept; a requester that keeps valid asserted while losing is granted at the next IDLE.
REQ-023 Requesters SHALL hold payload stable while valid and not ready; arbiter does not sample payload outside the accept cycle.
REQ-024 Unsupported op codes pass through unchanged; response reflects whatever the ALU returns (result 0, zero 1).
REQ-025 ALU drive registers hold their last value outside EXEC; no combinational path from reqN inputs to alu_* outputs.
REQ-026 resp_valid and reqN_ready never high in the same cycle.
REQ-027 valid deasserted by a requester before acceptance: request withdrawn, no response generated.

Reset
REQ-028 reset high at a clock edge forces IDLE, priority pointer = RR_INIT, resp_valid 0, resp_id 0, resp_result 0, resp_zero 0, alu_op 0, alu_a 0, alu_b 0, alu_shamt 0.
REQ-029 During reset cycle both reqN_ready are 0; reset mid-EXEC or mid-RESP discards the in-flight operation, no response issued.
REQ-030 First grant possible in the first cycle after reset deasserts.

Verification
REQ-031 req0 only, ADD a=5 b=7, resp_ready=1 -> ready0 at cycle N, resp_valid at N+2, resp_id 0, result 12, zero 0.
REQ-032 Both valid every cycle after reset (RR_INIT=0), req0 SUB 9-9, req1 OR 0xF0|0x0F -> grants alternate 0,1,0; responses result 0/zero 1 then 0xFF/zero 0.
REQ-033 req1 SHIFT a=1 shamt=31, resp_ready held low 5 cycles -> resp_valid held, result 0x80000000 stable, no ready asserted, IDLE one cycle after resp_ready.
REQ-034 req0 op 0111 a=3 b=4 -> result 0, zero 1, resp_id 0.
REQ-035 reset pulsed in EXEC of req0 NOR 0,0 -> no resp_valid, all outputs 0, next grant goes to requester 0.
